// File: rtl/byte_data_memory.sv
// Byte-wide data memory with fixed multi-cycle access latency.
// Requests are captured in IDLE, held through BUSY, and completed in DONE.
module byte_data_memory #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [7:0]  mem_writedata,
  output logic [7:0]  mem_readdata,
  output logic        mem_busywait,
  output logic        mem_error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        op_wr;
  logic [31:0] addr_q;
  logic [7:0]  wdata_q;
  logic        oor_q;
  logic [7:0]  mem [DEPTH];

  logic req_ok;
  logic req_bad;
  logic fire;
  logic oor;

  assign req_ok  = mem_read ^ mem_write;
  assign req_bad = mem_read & mem_write;
  assign fire    = (state == BUSY) &&
                   (cnt == 4'(LATENCY - 1));
  assign oor     = |addr_q[31:AW];

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mem_busywait = 1'b0;
    mem_error    = 1'b0;
    unique case (state)
      IDLE: begin
        mem_busywait = req_ok;
        mem_error    = req_bad;
        if (req_ok) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'd0;
        end
      end
      BUSY: begin
        mem_busywait = 1'b1;
        cnt_nxt      = cnt + 4'd1;
        if (fire) state_nxt = DONE;
      end
      DONE: begin
        mem_error = oor_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs stay quiet for the whole time reset is held.
    if (reset) begin
      mem_busywait = 1'b0;
      mem_error    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      op_wr        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 8'd0;
      oor_q        <= 1'b0;
      mem_readdata <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_ok) begin
        op_wr   <= mem_write;
        addr_q  <= mem_address;
        wdata_q <= mem_writedata;
        oor_q   <= 1'b0;
      end
      if (fire) begin
        oor_q <= oor;
        if (!op_wr)
          mem_readdata <= oor ? 8'h00
                              : mem[addr_q[AW-1:0]];
      end
    end
  end

  // Array has no reset; an aborted write never reaches fire.
  always_ff @(posedge clock) begin
    if (fire && op_wr && !oor)
      mem[addr_q[AW-1:0]] <= wdata_q;
  end

endmodule
